// File: rtl/axi_common_types_pkg.sv
// ---------------------------------------------------------------------------
// axi_common_types_pkg
// Shared AXI widths, burst/response encodings and the FSM state types used by
// the simple AXI slave memory and its address generator.
// ---------------------------------------------------------------------------
package axi_common_types_pkg;

    localparam int AXI_ID_WIDTH    = 4;
    localparam int AXI_ADDR_WIDTH  = 32;
    localparam int AXI_DATA_WIDTH  = 32;
    localparam int AXI_STRB_WIDTH  = AXI_DATA_WIDTH / 8;
    localparam int AXI_LEN_WIDTH   = 8;
    localparam int AXI_BURST_WIDTH = 2;
    localparam int AXI_RESP_WIDTH  = 2;
    localparam int AXI_USER_WIDTH  = 1;

    localparam logic [AXI_BURST_WIDTH-1:0] BURST_FIXED = 2'b00;
    localparam logic [AXI_BURST_WIDTH-1:0] BURST_INCR  = 2'b01;

    localparam logic [AXI_RESP_WIDTH-1:0] RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_WIDTH-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    // Only FIXED and INCR are served; WRAP and the reserved code are errors.
    function automatic logic burst_supported(input logic [AXI_BURST_WIDTH-1:0] burst);
        return (burst == BURST_FIXED) || (burst == BURST_INCR);
    endfunction

endpackage

// File: rtl/axi_slv_addr_gen.sv
// ---------------------------------------------------------------------------
// axi_slv_addr_gen
// Combinational per-beat address helper: computes the address of the following
// beat, whether the current beat falls inside the memory region, and the word
// index of the current beat inside the storage array.
//   addr      : byte address of the current beat
//   burst     : AXI burst type of the transaction
//   next_addr : byte address of the next beat (FIXED holds, otherwise +STRB)
//   in_range  : current beat lies in BASE_ADDR .. BASE_ADDR+DEPTH*STRB-1
//   word_idx  : word index of the current beat (meaningful when in_range)
// ---------------------------------------------------------------------------
module axi_slv_addr_gen
    import axi_common_types_pkg::*;
#(
    parameter int                        DEPTH     = 256,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic [AXI_ADDR_WIDTH-1:0]  addr,
    input  logic [AXI_BURST_WIDTH-1:0] burst,
    output logic [AXI_ADDR_WIDTH-1:0]  next_addr,
    output logic                       in_range,
    output logic [$clog2(DEPTH)-1:0]   word_idx
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(AXI_STRB_WIDTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] REGION_BYTES = AXI_ADDR_WIDTH'(DEPTH * AXI_STRB_WIDTH);

    logic [AXI_ADDR_WIDTH-1:0] offset;

    assign offset    = addr - BASE_ADDR;
    // The lower bound test matters because offset wraps for addresses below the base.
    assign in_range  = (addr >= BASE_ADDR) && (offset < REGION_BYTES);
    assign word_idx  = offset[IDX_W+OFF_W-1:OFF_W];
    assign next_addr = (burst == BURST_FIXED) ? addr : addr + AXI_ADDR_WIDTH'(AXI_STRB_WIDTH);

endmodule

// File: rtl/axi_slave_mem.sv
// ---------------------------------------------------------------------------
// axi_slave_mem
// AXI4 slave backed by a DEPTH-word memory. Independent write (AW/W/B) and
// read (AR/R) state machines, one outstanding transaction per direction.
// FIXED and INCR bursts are served; out-of-range beats, WRAP/reserved bursts
// and WLAST mismatches produce SLVERR and never write.
//   ACLK/ARESETn            : clock, asynchronous active-low reset
//   AW*, W*, B*             : write address, write data, write response
//   AR*, R*                 : read address, read data
//   Ax{LOCK,SIZE,CACHE,PROT,QOS,REGION,USER}, WUSER : accepted and ignored
//   BUSER, RUSER            : tied to zero
// ---------------------------------------------------------------------------
module axi_slave_mem
    import axi_common_types_pkg::*;
#(
    parameter int                        DEPTH     = 256,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic [AXI_ID_WIDTH-1:0]    AWID,
    input  logic [AXI_ADDR_WIDTH-1:0]  AWADDR,
    input  logic [AXI_LEN_WIDTH-1:0]   AWLEN,
    input  logic [AXI_BURST_WIDTH-1:0] AWBURST,
    input  logic                       AWLOCK,
    input  logic [2:0]                 AWSIZE,
    input  logic [3:0]                 AWCACHE,
    input  logic [2:0]                 AWPROT,
    input  logic [3:0]                 AWQOS,
    input  logic [3:0]                 AWREGION,
    input  logic [AXI_USER_WIDTH-1:0]  AWUSER,
    input  logic                       AWVALID,
    output logic                       AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]  WDATA,
    input  logic [AXI_STRB_WIDTH-1:0]  WSTRB,
    input  logic                       WLAST,
    input  logic [AXI_USER_WIDTH-1:0]  WUSER,
    input  logic                       WVALID,
    output logic                       WREADY,
    output logic [AXI_ID_WIDTH-1:0]    BID,
    output logic [AXI_RESP_WIDTH-1:0]  BRESP,
    output logic [AXI_USER_WIDTH-1:0]  BUSER,
    output logic                       BVALID,
    input  logic                       BREADY,
    input  logic [AXI_ID_WIDTH-1:0]    ARID,
    input  logic [AXI_ADDR_WIDTH-1:0]  ARADDR,
    input  logic [AXI_LEN_WIDTH-1:0]   ARLEN,
    input  logic [AXI_BURST_WIDTH-1:0] ARBURST,
    input  logic                       ARLOCK,
    input  logic [2:0]                 ARSIZE,
    input  logic [3:0]                 ARCACHE,
    input  logic [2:0]                 ARPROT,
    input  logic [3:0]                 ARQOS,
    input  logic [3:0]                 ARREGION,
    input  logic [AXI_USER_WIDTH-1:0]  ARUSER,
    input  logic                       ARVALID,
    output logic                       ARREADY,
    output logic [AXI_ID_WIDTH-1:0]    RID,
    output logic [AXI_DATA_WIDTH-1:0]  RDATA,
    output logic [AXI_RESP_WIDTH-1:0]  RRESP,
    output logic                       RLAST,
    output logic [AXI_USER_WIDTH-1:0]  RUSER,
    output logic                       RVALID,
    input  logic                       RREADY
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [AXI_LEN_WIDTH:0]   W_CNT_ONE = 1;
    localparam logic [AXI_LEN_WIDTH-1:0] R_CNT_ONE = 1;

    logic unused_inputs;
    assign unused_inputs = ^{AWLOCK, AWSIZE, AWCACHE, AWPROT, AWQOS, AWREGION, AWUSER,
                             ARLOCK, ARSIZE, ARCACHE, ARPROT, ARQOS, ARREGION, ARUSER, WUSER};
    assign BUSER = '0;
    assign RUSER = '0;

    logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------- write side ----------------
    w_state_e                   w_state;
    logic [AXI_ID_WIDTH-1:0]    w_id;
    logic [AXI_ADDR_WIDTH-1:0]  w_addr, w_next;
    logic [AXI_LEN_WIDTH-1:0]   w_len;
    logic [AXI_BURST_WIDTH-1:0] w_burst;
    logic [AXI_LEN_WIDTH:0]     w_cnt;
    logic                       w_err, w_in_range, w_fire, w_beat_err, w_we;
    logic [IDX_W-1:0]           w_idx;

    axi_slv_addr_gen #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_wr_addr (
        .addr(w_addr), .burst(w_burst), .next_addr(w_next),
        .in_range(w_in_range), .word_idx(w_idx)
    );

    // A beat is erroneous if out of range, the burst is unsupported, it lies
    // beyond AWLEN+1 (w_cnt is one wider and saturates), or WLAST disagrees
    // with the announced length. Erroneous beats never touch memory.
    assign w_fire     = WVALID && WREADY;
    assign w_beat_err = !w_in_range || !burst_supported(w_burst) ||
                        (w_cnt > {1'b0, w_len}) || (WLAST && (w_cnt != {1'b0, w_len}));
    assign w_we       = w_fire && !w_beat_err;

    always_ff @(posedge ACLK) begin
        if (w_we) begin
            for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
                if (WSTRB[b]) mem[w_idx][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state <= W_IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BID     <= '0;
            BRESP   <= '0;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    AWREADY <= 1'b1;
                    if (AWVALID && AWREADY) begin
                        w_id    <= AWID;
                        w_addr  <= AWADDR;
                        w_len   <= AWLEN;
                        w_burst <= AWBURST;
                        w_cnt   <= '0;
                        w_err   <= 1'b0;
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b1;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_addr <= w_next;
                        if (w_cnt != '1) w_cnt <= w_cnt + W_CNT_ONE;
                        if (w_beat_err) w_err <= 1'b1;
                        if (WLAST) begin
                            WREADY  <= 1'b0;
                            BVALID  <= 1'b1;
                            BID     <= w_id;
                            BRESP   <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ---------------- read side ----------------
    r_state_e                   r_state;
    logic [AXI_ADDR_WIDTH-1:0]  r_addr, r_gen_addr, r_next;
    logic [AXI_LEN_WIDTH-1:0]   r_len, r_cnt;
    logic [AXI_BURST_WIDTH-1:0] r_burst, r_gen_burst;
    logic                       r_in_range;
    logic [IDX_W-1:0]           r_idx;
    logic [AXI_DATA_WIDTH-1:0]  rd_word, rd_beat_data;
    logic [AXI_RESP_WIDTH-1:0]  rd_beat_resp;

    // r_addr always holds the address of the next beat to be loaded, so the
    // generator looks at ARADDR while idle and at r_addr mid-burst.
    assign r_gen_addr  = (r_state == R_IDLE) ? ARADDR  : r_addr;
    assign r_gen_burst = (r_state == R_IDLE) ? ARBURST : r_burst;

    axi_slv_addr_gen #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_rd_addr (
        .addr(r_gen_addr), .burst(r_gen_burst), .next_addr(r_next),
        .in_range(r_in_range), .word_idx(r_idx)
    );

    // Merge a write landing on the same edge so a loaded beat already sees it.
    always_comb begin
        rd_word = mem[r_idx];
        if (w_we && (w_idx == r_idx)) begin
            for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
                if (WSTRB[b]) rd_word[8*b +: 8] = WDATA[8*b +: 8];
            end
        end
        rd_beat_data = '0;
        rd_beat_resp = RESP_SLVERR;
        if (r_in_range && burst_supported(r_gen_burst)) begin
            rd_beat_data = rd_word;
            rd_beat_resp = RESP_OKAY;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            RID     <= '0;
            RDATA   <= '0;
            RRESP   <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    ARREADY <= 1'b1;
                    if (ARVALID && ARREADY) begin
                        RID     <= ARID;
                        r_len   <= ARLEN;
                        r_burst <= ARBURST;
                        r_addr  <= r_next;
                        r_cnt   <= '0;
                        RVALID  <= 1'b1;
                        RDATA   <= rd_beat_data;
                        RRESP   <= rd_beat_resp;
                        RLAST   <= (ARLEN == '0);
                        ARREADY <= 1'b0;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RVALID && RREADY) begin
                        if (RLAST) begin
                            RVALID  <= 1'b0;
                            RLAST   <= 1'b0;
                            ARREADY <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_cnt  <= r_cnt + R_CNT_ONE;
                            r_addr <= r_next;
                            RDATA  <= rd_beat_data;
                            RRESP  <= rd_beat_resp;
                            RLAST  <= ((r_cnt + R_CNT_ONE) == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_axi_slave_mem
// Randomized self-checking bench for axi_slave_mem. Stimulus tasks push the
// expected B and R responses, computed from a word-array reference memory,
// into queues; two monitors pop and compare on every B/R handshake.
// ---------------------------------------------------------------------------
module tb_axi_slave_mem;
    import axi_common_types_pkg::*;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0;

    logic        ACLK, ARESETn;
    logic [3:0]  AWID, ARID, BID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [7:0]  AWLEN, ARLEN;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [0:0]  BUSER, RUSER;

    axi_slave_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST),
        .AWLOCK(1'b0), .AWSIZE(3'd2), .AWCACHE(4'd0), .AWPROT(3'd0), .AWQOS(4'd0),
        .AWREGION(4'd0), .AWUSER(1'b0), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WUSER(1'b0), .WVALID(WVALID),
        .WREADY(WREADY), .BID(BID), .BRESP(BRESP), .BUSER(BUSER), .BVALID(BVALID),
        .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST),
        .ARLOCK(1'b0), .ARSIZE(3'd2), .ARCACHE(4'd0), .ARPROT(3'd0), .ARQOS(4'd0),
        .ARREGION(4'd0), .ARUSER(1'b0), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RUSER(RUSER),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    b_exp_t      b_exp_q[$];
    r_exp_t      r_exp_q[$];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wr_data [17];
    logic [3:0]  wr_strb [17];
    int          checks   = 0;
    int          failures = 0;
    int          b_seen   = 0;
    int          r_seen   = 0;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic in_region(input longint a);
        return (a >= longint'(BASE)) && (a < longint'(BASE) + DEPTH * 4);
    endfunction

    function automatic logic burst_ok_ref(input logic [1:0] burst);
        return (burst == 2'b00) || (burst == 2'b01);
    endfunction

    function automatic longint beat_addr(input logic [31:0] addr, input logic [1:0] burst, input int i);
        return (burst == 2'b00) ? longint'(addr) : longint'(addr) + 4 * i;
    endfunction

    // Random RREADY so read beats are stalled now and then.
    initial begin
        RREADY = 1'b0;
        forever begin
            @(posedge ACLK);
            #1;
            RREADY = ($urandom_range(0, 9) < 7);
        end
    end

    // B monitor: compares on the cycle before the handshake edge.
    always @(negedge ACLK) begin
        if (ARESETn && BVALID && BREADY) begin
            if (b_exp_q.size() == 0) begin
                check_output("b_unexpected", 64'(BVALID), 64'(0));
            end else begin
                b_exp_t e;
                e = b_exp_q.pop_front();
                check_output("bid", 64'(BID), 64'(e.id));
                check_output("bresp", 64'(BRESP), 64'(e.resp));
                check_output("buser", 64'(BUSER), 64'(0));
            end
            b_seen++;
        end
    end

    // R monitor.
    always @(negedge ACLK) begin
        if (ARESETn && RVALID && RREADY) begin
            if (r_exp_q.size() == 0) begin
                check_output("r_unexpected", 64'(RVALID), 64'(0));
            end else begin
                r_exp_t e;
                e = r_exp_q.pop_front();
                check_output("rid", 64'(RID), 64'(e.id));
                check_output("rdata", 64'(RDATA), 64'(e.data));
                check_output("rresp", 64'(RRESP), 64'(e.resp));
                check_output("rlast", 64'(RLAST), 64'(e.last));
            end
            r_seen++;
        end
    end

    // Updates the reference memory, queues the expected B response and drives
    // AW, the W beats (WLAST on beat last_beat) and B with an optional stall.
    task automatic write_txn(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int last_beat, input int bready_delay);
        logic   err;
        longint a;
        int     n, b_start;
        b_exp_t e;
        err = !burst_ok_ref(burst) || (last_beat != int'(len));
        for (int i = 0; i <= last_beat; i++) begin
            a = beat_addr(addr, burst, i);
            if (!in_region(a) || i > int'(len)) err = 1'b1;
            else if (burst_ok_ref(burst) && !(i == last_beat && last_beat != int'(len))) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_strb[i][b]) ref_mem[int'((a - longint'(BASE)) / 4)][8*b +: 8] = wr_data[i][8*b +: 8];
                end
            end
        end
        e.id = id;
        e.resp = err ? 2'b10 : 2'b00;
        b_exp_q.push_back(e);
        b_start = b_seen;

        AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!AWREADY && n < 100) begin n++; @(negedge ACLK); end
        check_output("aw_ready", 64'(AWREADY), 64'(1));
        @(posedge ACLK); #1;
        AWVALID = 1'b0;

        for (int i = 0; i <= last_beat; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                WVALID = 1'b0;
                @(posedge ACLK); #1;
            end
            WVALID = 1'b1; WDATA = wr_data[i]; WSTRB = wr_strb[i]; WLAST = (i == last_beat);
            n = 0;
            @(negedge ACLK);
            while (!WREADY && n < 100) begin n++; @(negedge ACLK); end
            check_output("w_ready", 64'(WREADY), 64'(1));
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;

        @(negedge ACLK);
        check_output("b_valid_next", 64'(BVALID), 64'(1));
        for (int d = 0; d < bready_delay; d++) begin
            @(posedge ACLK); #1;
            @(negedge ACLK);
            check_output("b_hold_valid", 64'(BVALID), 64'(1));
            check_output("b_hold_id", 64'(BID), 64'(id));
        end
        @(posedge ACLK); #1;
        BREADY = 1'b1;
        n = 0;
        while (b_seen == b_start && n < 50) begin n++; @(negedge ACLK); #1; end
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        check_output("b_handshakes", 64'(b_seen - b_start), 64'(1));
    endtask

    task automatic push_read_expect(input logic [3:0] id, input logic [31:0] addr,
                                    input logic [7:0] len, input logic [1:0] burst);
        r_exp_t e;
        longint a;
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, burst, i);
            e.id   = id;
            e.last = (i == int'(len));
            if (in_region(a) && burst_ok_ref(burst)) begin
                e.data = ref_mem[int'((a - longint'(BASE)) / 4)];
                e.resp = 2'b00;
            end else begin
                e.data = 32'h0;
                e.resp = 2'b10;
            end
            r_exp_q.push_back(e);
        end
    endtask

    task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
        int n;
        ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!ARREADY && n < 100) begin n++; @(negedge ACLK); end
        check_output("ar_ready", 64'(ARREADY), 64'(1));
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
    endtask

    task automatic read_txn(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
        int target, n;
        target = r_seen + int'(len) + 1;
        push_read_expect(id, addr, len, burst);
        issue_ar(id, addr, len, burst);
        n = 0;
        while (r_seen < target && n < 500) begin n++; @(negedge ACLK); #1; end
        check_output("r_beats", 64'(r_seen), 64'(target));
        @(posedge ACLK); #1;
    endtask

    task automatic fill_beats(input int count);
        for (int i = 0; i < count; i++) begin
            wr_data[i] = $urandom;
            wr_strb[i] = 4'hF;
        end
    endtask

    // Randomized write/read pairs, including boundary-crossing bursts, FIXED
    // and unsupported bursts, early/late WLAST and delayed BREADY.
    task automatic apply_stimulus(input int count);
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        int          last_beat, r;
        for (int t = 0; t < count; t++) begin
            if ($urandom_range(0, 9) < 8) addr = 32'(4 * $urandom_range(0, DEPTH - 1));
            else                          addr = 32'(4 * $urandom_range(DEPTH - 8, DEPTH + 8));
            len = 8'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            burst = (r < 6) ? 2'b01 : (r < 9) ? 2'b00 : 2'($urandom_range(2, 3));
            r = $urandom_range(0, 9);
            if (r == 0)      last_beat = (len > 0) ? int'(len) - 1 : int'(len) + 1;
            else if (r == 1) last_beat = int'(len) + 1;
            else             last_beat = int'(len);
            for (int i = 0; i <= last_beat; i++) begin
                wr_data[i] = $urandom;
                wr_strb[i] = 4'($urandom_range(0, 15));
            end
            write_txn(4'($urandom), addr, len, burst, last_beat, $urandom_range(0, 2));
            r = $urandom_range(0, 9);
            burst = (r < 7) ? 2'b01 : (r < 9) ? 2'b00 : 2'b10;
            read_txn(4'($urandom), addr, len, burst);
        end
    endtask

    initial begin
        int start, n;
        ARESETn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARBURST = '0; ARVALID = 1'b0;

        #12;
        check_output("rst_awready", 64'(AWREADY), 64'(0));
        check_output("rst_arready", 64'(ARREADY), 64'(0));
        check_output("rst_valids", 64'({WREADY, BVALID, RVALID, RLAST}), 64'(0));
        check_output("rst_ids_resps", 64'({BID, BRESP, RID, RRESP}), 64'(0));
        check_output("rst_rdata", 64'(RDATA), 64'(0));
        check_output("rst_user", 64'({BUSER, RUSER}), 64'(0));
        #10;
        ARESETn = 1'b1;
        #1;
        check_output("exit_awready_low", 64'(AWREADY), 64'(0));
        @(posedge ACLK); #1;
        check_output("exit_awready", 64'(AWREADY), 64'(1));
        check_output("exit_arready", 64'(ARREADY), 64'(1));

        // Fill the whole region so every later read has known contents.
        for (int w = 0; w < DEPTH; w += 16) begin
            fill_beats(16);
            write_txn(4'(w / 16), 32'(BASE) + 32'(4 * w), 8'd15, 2'b01, 15, 0);
        end

        // Four-beat INCR write then read-back of 1,2,3,4.
        for (int i = 0; i < 4; i++) begin wr_data[i] = 32'(i + 1); wr_strb[i] = 4'hF; end
        write_txn(4'h5, 32'h10, 8'd3, 2'b01, 3, 0);
        read_txn(4'h3, 32'h10, 8'd3, 2'b01);

        // Single-byte strobe merge: expect 0x112233DD.
        wr_data[0] = 32'h11223344; wr_strb[0] = 4'hF;
        write_txn(4'h1, 32'h40, 8'd0, 2'b01, 0, 0);
        wr_data[0] = 32'hAABBCCDD; wr_strb[0] = 4'h1;
        write_txn(4'h2, 32'h40, 8'd0, 2'b01, 0, 1);
        check_output("merge_model", 64'(ref_mem[16]), 64'(32'h112233DD));
        read_txn(4'h4, 32'h40, 8'd0, 2'b01);

        // Burst running off the top of the region.
        fill_beats(2);
        write_txn(4'h6, 32'(BASE) + 32'(DEPTH * 4 - 4), 8'd1, 2'b01, 1, 0);
        read_txn(4'h7, 32'(BASE) + 32'(DEPTH * 4 - 4), 8'd1, 2'b01);

        // Early WLAST with BREADY held low for five cycles.
        fill_beats(2);
        write_txn(4'h9, 32'h80, 8'd3, 2'b01, 1, 5);
        read_txn(4'h8, 32'h80, 8'd3, 2'b01);

        // Simultaneous AW and AR on disjoint addresses.
        fill_beats(4);
        fork
            write_txn(4'hA, 32'h200, 8'd3, 2'b01, 3, 0);
            read_txn(4'hB, 32'h100, 8'd3, 2'b01);
        join

        apply_stimulus(40);

        // Reset in the middle of a four-beat read.
        start = r_seen;
        push_read_expect(4'hC, 32'h10, 8'd3, 2'b01);
        issue_ar(4'hC, 32'h10, 8'd3, 2'b01);
        n = 0;
        while (r_seen < start + 2 && n < 200) begin n++; @(negedge ACLK); #1; end
        check_output("mid_burst_beats", 64'(r_seen >= start + 2), 64'(1));
        @(posedge ACLK); #2;
        ARESETn = 1'b0;
        #1;
        check_output("midrst_rvalid", 64'(RVALID), 64'(0));
        check_output("midrst_rlast", 64'(RLAST), 64'(0));
        check_output("midrst_arready", 64'(ARREADY), 64'(0));
        check_output("midrst_rdata", 64'(RDATA), 64'(0));
        r_exp_q.delete();
        #10;
        ARESETn = 1'b1;
        #1;
        check_output("midrst_exit_arready_low", 64'(ARREADY), 64'(0));
        @(posedge ACLK); #1;
        check_output("midrst_exit_arready", 64'(ARREADY), 64'(1));
        check_output("midrst_exit_awready", 64'(AWREADY), 64'(1));
        read_txn(4'hD, 32'h10, 8'd3, 2'b01);
        read_txn(4'hE, 32'h40, 8'd0, 2'b01);

        repeat (3) @(posedge ACLK);
        check_output("b_queue_empty", 64'(b_exp_q.size()), 64'(0));
        check_output("r_queue_empty", 64'(r_exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 Parameter DEPTH, 256, number of AXI_DATA_WIDTH-bit words stored.
REQ-002 Parameter BASE_ADDR, 0, byte address of word 0; region is BASE_ADDR .. BASE_ADDR+DEPTH*AXI_STRB_WIDTH-1.
REQ-003 ACLK  in  1  single clock; all logic on posedge.
REQ-004 ARESETn  in  1  reset, asynchronous assert, active-low.
REQ-005 AWID  in  AXI_ID_WIDTH  write ID.
REQ-006 AWADDR  in  AXI_ADDR_WIDTH  write start byte address.
REQ-007 AWLEN  in  AXI_LEN_WIDTH  beats-1 (0-15).
REQ-008 AWBURST  in  AXI_BURST_WIDTH  burst type.
REQ-009 AWVALID  in  1  AW valid.
REQ-010 AWREADY  out  1  AW ready.
REQ-011 WDATA  in  AXI_DATA_WIDTH  write data.
REQ-012 WSTRB  in  AXI_STRB_WIDTH  byte enables.
REQ-013 WLAST  in  1  last write beat.
REQ-014 WVALID  in  1  W valid.
REQ-015 WREADY  out  1  W ready.
REQ-016 BID  out  AXI_ID_WIDTH  response ID (= captured AWID).
REQ-017 BRESP  out  AXI_RESP_WIDTH  write response.
REQ-018 BVALID  out  1  B valid.
REQ-019 BREADY  in  1  B ready.
REQ-020 ARID  in  AXI_ID_WIDTH  read ID.
REQ-021 ARADDR  in  AXI_ADDR_WIDTH  read start byte address.
REQ-022 ARLEN  in  AXI_LEN_WIDTH  beats-1.
REQ-023 ARBURST  in  AXI_BURST_WIDTH  burst type.
REQ-024 ARVALID  in  1  AR valid.
REQ-025 ARREADY  out  1  AR ready.
REQ-026 RID  out  AXI_ID_WIDTH  read ID (= captured ARID).
REQ-027 RDATA  out  AXI_DATA_WIDTH  read data.
REQ-028 RRESP  out  AXI_RESP_WIDTH  read response.
REQ-029 RLAST  out  1  last read beat.
REQ-030 RVALID  out  1  R valid.
REQ-031 RREADY  in  1  R ready.
REQ-032 Inputs AxLOCK, AxSIZE, AxCACHE, AxPROT, AxQOS, AxREGION, AxUSER, WUSER SHALL be present and ignored; BUSER/RUSER SHALL drive 0; all transfers are full width.

Function
REQ-033 Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE: AWREADY=1 only in W_IDLE; AW handshake at edge N captures ID/addr/len/burst, WREADY=1 from N+1 in W_DATA.
REQ-034 Each W handshake with in-range, OKAY-eligible address SHALL update only bytes with WSTRB=1 at that edge; INCR adds AXI_STRB_WIDTH per beat, FIXED holds address.
REQ-035 W_DATA ends only on WLAST handshake; BVALID=1 next cycle, held with BID/BRESP stable until BREADY, then W_IDLE (AWREADY=1 same cycle as BVALID drops).
REQ-036 BRESP/RRESP=SLVERR (2'b10) if any beat is outside the region, burst is WRAP or reserved, or WLAST arrives on a beat other than AWLEN+1; else OKAY; beats beyond AWLEN+1 and erroneous beats SHALL not write.
REQ-037 Read FSM R_IDLE->R_DATA->R_IDLE: ARREADY=1 only in R_IDLE; AR handshake at N gives RVALID=1 at N+1; each beat held stable until RREADY; RLAST=1 on beat ARLEN+1, after which R_IDLE next cycle.
REQ-038 RDATA SHALL reflect every write committed at or before the edge presenting that beat; out-of-range or erroneous beats return RDATA=0 with SLVERR, all ARLEN+1 beats still issued.
REQ-039 Read and write FSMs SHALL be independent; simultaneous AW and AR handshakes both accepted; one outstanding transaction per direction.

Reset
REQ-040 ARESETn low SHALL immediately force both FSMs idle, AWREADY=ARREADY=1 after reset exit only, WREADY=BVALID=RVALID=RLAST=0, BID/BRESP/RID/RRESP/RDATA=0, aborting any burst mid-flight; memory contents SHALL not be cleared.

Structure
REQ-041 Resp/burst encodings and widths SHALL come from axi_common_types_pkg; FSM state enums belong in that package; one sub-module axi_slv_addr_gen (next-address and range check) instantiated per direction.

Verification
REQ-042 AW addr 0x10 len 3 INCR, WDATA 1..4 strb 0xF -> BRESP OKAY, BID=AWID; AR 0x10 len 3 -> RDATA 1,2,3,4, RLAST on beat 4.
REQ-043 WSTRB 0x1 WDATA 0xAABBCCDD over word 0x11223344 -> readback 0x112233DD.
REQ-044 AW addr BASE_ADDR+DEPTH*AXI_STRB_WIDTH-4 len 1 INCR -> beat 2 not written, BRESP SLVERR; read same -> beat1 OKAY data, beat2 0/SLVERR.
REQ-045 AWLEN 3 with WLAST on beat 2 -> BVALID next cycle, BRESP SLVERR; BREADY low 5 cycles -> BVALID/BID held.
REQ-046 RREADY toggling during 4-beat read, ARESETn pulsed low mid-burst -> RVALID 0 immediately, ARREADY 1 after release, prior memory contents readable.
